// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, reads instruction memory combinationally, and buffers
// {pc, instr, excp} entries in a small FIFO presented to decode via valid/ready.
`ifndef XLEN_32b
`define XLEN_32b 1
`endif
`ifndef XLEN_64b
`define XLEN_64b 2
`endif

module instr_fetch_unit #(
  parameter int          XLEN       = `XLEN_64b,
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int          FIFO_DEPTH = 4,
  localparam int         W          = 1 << (XLEN + 4)
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_redirect,
  input  logic [W-1:0] i_redirect_pc,
  output logic [W-1:0] o_imem_adr,
  input  logic [31:0]  i_imem_instr,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [31:0]  o_instr,
  output logic [W-1:0] o_pc,
  output logic [W-1:0] o_pc_plus4,
  output logic         o_excp_misalign,
  output logic [1:0]   o_dbg_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] ST_FETCH    = 2'd0;
  localparam logic [1:0] ST_MISALIGN = 2'd1;
  localparam logic [1:0] ST_HALT     = 2'd2;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Handshake: an entry moves to decode on a cycle where o_valid & i_ready are both
  // high and no redirect is present; a redirect always wins and drops the head.

  logic [W-1:0]  r_pc;
  logic [1:0]    state;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic [W-1:0]  mem_pc    [FIFO_DEPTH];
  logic [31:0]   mem_instr [FIFO_DEPTH];
  logic          mem_excp  [FIFO_DEPTH];

  logic has_entry;
  logic pop;
  logic has_room;
  logic push_fetch;
  logic push_mark;
  logic push;

  assign has_entry  = (count != '0);
  assign pop        = has_entry & i_ready & ~i_redirect;
  assign has_room   = (count < CW'(FIFO_DEPTH)) | pop;
  assign push_fetch = (state == ST_FETCH) & ~i_redirect & has_room;
  assign push_mark  = (state == ST_MISALIGN) & ~i_redirect & has_room;
  assign push       = push_fetch | push_mark;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_pc   <= RESET_PC[W-1:0];
      state  <= ST_FETCH;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (i_redirect) begin
      r_pc   <= i_redirect_pc;
      state  <= (i_redirect_pc[1:0] != 2'b00) ? ST_MISALIGN : ST_FETCH;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (push_fetch) r_pc <= r_pc + W'(4);
      // The marker carries the faulting target PC; fetch then parks until redirected.
      if (push_mark)  state <= ST_HALT;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_pc[wr_ptr]    <= r_pc;
      mem_instr[wr_ptr] <= push_mark ? NOP_INSTR : i_imem_instr;
      mem_excp[wr_ptr]  <= push_mark;
    end
  end

  assign o_imem_adr      = r_pc;
  assign o_valid         = has_entry;
  assign o_pc            = has_entry ? mem_pc[rd_ptr] : '0;
  assign o_pc_plus4      = has_entry ? mem_pc[rd_ptr] + W'(4) : '0;
  assign o_instr         = has_entry ? mem_instr[rd_ptr] : '0;
  assign o_excp_misalign = has_entry & mem_excp[rd_ptr];
  assign o_dbg_state     = state;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: scoreboarded delivery stream on a 64-bit instance plus
// directed checks, and a 32-bit instance for PC wrap-around.
`ifndef XLEN_32b
`define XLEN_32b 1
`endif
`ifndef XLEN_64b
`define XLEN_64b 2
`endif

module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic [63:0] imem_adr;
  logic [31:0] imem_instr;
  logic        valid;
  logic        ready;
  logic [31:0] instr;
  logic [63:0] pc;
  logic [63:0] pc_plus4;
  logic        excp;
  logic [1:0]  dbg_state;

  logic        redirect2;
  logic [31:0] redirect_pc2;
  logic [31:0] imem_adr2;
  logic [31:0] imem_instr2;
  logic        valid2;
  logic        ready2;
  logic [31:0] instr2;
  logic [31:0] pc2;
  logic [31:0] pc_plus4_2;
  logic        excp2;
  logic [1:0]  dbg_state2;

  int checks = 0;
  int failures = 0;

  // Entries are {excp, pc}; the expected instruction is derived from them.
  logic [64:0] exp_q[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a == 64'h0)      return 32'h00A0_0093;
    else if (a == 64'h4) return 32'h0010_0113;
    else                 return a[33:2] ^ 32'h5A5A_0013;
  endfunction

  assign imem_instr  = mem_word(imem_adr);
  assign imem_instr2 = mem_word({32'd0, imem_adr2});

  instr_fetch_unit #(.XLEN(`XLEN_64b), .RESET_PC(64'h0), .FIFO_DEPTH(4)) dut (
    .i_clk(clk), .i_rst(rst_n), .i_redirect(redirect), .i_redirect_pc(redirect_pc),
    .o_imem_adr(imem_adr), .i_imem_instr(imem_instr), .o_valid(valid), .i_ready(ready),
    .o_instr(instr), .o_pc(pc), .o_pc_plus4(pc_plus4), .o_excp_misalign(excp),
    .o_dbg_state(dbg_state)
  );

  instr_fetch_unit #(.XLEN(`XLEN_32b), .RESET_PC(64'h0), .FIFO_DEPTH(4)) dut32 (
    .i_clk(clk), .i_rst(rst_n), .i_redirect(redirect2), .i_redirect_pc(redirect_pc2),
    .o_imem_adr(imem_adr2), .i_imem_instr(imem_instr2), .o_valid(valid2), .i_ready(ready2),
    .o_instr(instr2), .o_pc(pc2), .o_pc_plus4(pc_plus4_2), .o_excp_misalign(excp2),
    .o_dbg_state(dbg_state2)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_stream(input logic [63:0] start, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({1'b0, start + 64'(4 * i)});
  endtask

  // Scoreboard: every accepted head entry must be the next expected one.
  always @(negedge clk) begin
    logic [64:0] e;
    if (rst_n && valid && ready && !redirect) begin
      if (exp_q.size() == 0) begin
        chk("sb_extra_entry", {63'd0, valid}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_pc", pc, e[63:0]);
        chk("sb_pc_plus4", pc_plus4, e[63:0] + 64'd4);
        chk("sb_excp", {63'd0, excp}, {63'd0, e[64]});
        chk("sb_instr", {32'd0, instr}, {32'd0, e[64] ? 32'h0000_0013 : mem_word(e[63:0])});
      end
    end
  end

  initial begin
    rst_n = 1'b0; ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    redirect2 = 1'b0; redirect_pc2 = '0; ready2 = 1'b1;
    repeat (2) tick();

    chk("rst_valid", {63'd0, valid}, 64'd0);
    chk("rst_pc", pc, 64'd0);
    chk("rst_pc_plus4", pc_plus4, 64'd0);
    chk("rst_instr", {32'd0, instr}, 64'd0);
    chk("rst_excp", {63'd0, excp}, 64'd0);
    chk("rst_imem_adr", imem_adr, 64'd0);
    chk("rst_state", {62'd0, dbg_state}, 64'd0);

    exp_q.delete();
    push_stream(64'h0, 64);
    rst_n = 1'b1;
    tick();
    chk("first_valid", {63'd0, valid}, 64'd1);
    chk("first_pc", pc, 64'h0);

    // Stall with decode not ready: four entries buffered, fetch address frozen.
    repeat (10) tick();
    chk("stall_imem_adr", imem_adr, 64'h10);
    chk("stall_head_pc", pc, 64'h0);
    chk("stall_valid", {63'd0, valid}, 64'd1);

    ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      chk("stream_pc", pc, 64'(4 * k));
      chk("stream_pc_plus4", pc_plus4, 64'(4 * k + 4));
      chk("stream_instr", {32'd0, instr}, {32'd0, mem_word(64'(4 * k))});
      tick();
    end

    // Refill to full, then redirect while decode is ready.
    ready = 1'b0;
    repeat (6) tick();
    chk("full_imem_adr", imem_adr, 64'h38);
    chk("full_head_pc", pc, 64'h28);
    ready = 1'b1; redirect = 1'b1; redirect_pc = 64'h400;
    exp_q.delete();
    push_stream(64'h400, 64);
    tick();
    redirect = 1'b0;
    chk("redir_flush_valid", {63'd0, valid}, 64'd0);
    tick();
    chk("redir_target_valid", {63'd0, valid}, 64'd1);
    chk("redir_target_pc", pc, 64'h400);
    repeat (4) tick();
    chk("redir_stream_pc", pc, 64'h410);

    // Misaligned redirect: single marker entry, then halt.
    redirect = 1'b1; redirect_pc = 64'h402;
    exp_q.delete();
    exp_q.push_back({1'b1, 64'h402});
    tick();
    redirect = 1'b0;
    chk("mis_flush_valid", {63'd0, valid}, 64'd0);
    chk("mis_state", {62'd0, dbg_state}, 64'd1);
    tick();
    chk("mis_valid", {63'd0, valid}, 64'd1);
    chk("mis_pc", pc, 64'h402);
    chk("mis_instr", {32'd0, instr}, 64'h13);
    chk("mis_excp", {63'd0, excp}, 64'd1);
    chk("mis_pc_plus4", pc_plus4, 64'h406);
    chk("mis_halt_state", {62'd0, dbg_state}, 64'd2);
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("halt_valid", {63'd0, valid}, 64'd0);
      chk("halt_imem_adr", imem_adr, 64'h402);
      tick();
    end

    redirect = 1'b1; redirect_pc = 64'h500;
    exp_q.delete();
    push_stream(64'h500, 64);
    tick();
    redirect = 1'b0;
    tick();
    chk("resume_pc", pc, 64'h500);
    tick();
    chk("resume_pc_next", pc, 64'h504);

    // 32-bit instance: PC wraps to zero.
    redirect2 = 1'b1; redirect_pc2 = 32'hFFFF_FFFC;
    tick();
    redirect2 = 1'b0;
    tick();
    chk("wrap_pc_top", {32'd0, pc2}, 64'hFFFF_FFFC);
    chk("wrap_pc_plus4_top", {32'd0, pc_plus4_2}, 64'h0);
    chk("wrap_instr_top", {32'd0, instr2}, {32'd0, mem_word(64'hFFFF_FFFC)});
    tick();
    chk("wrap_pc_zero", {32'd0, pc2}, 64'h0);
    chk("wrap_pc_plus4_zero", {32'd0, pc_plus4_2}, 64'h4);

    // Reset mid-stream with three entries buffered.
    ready = 1'b0; redirect = 1'b1; redirect_pc = 64'h800;
    exp_q.delete();
    push_stream(64'h800, 64);
    tick();
    redirect = 1'b0;
    repeat (3) tick();
    chk("pre_rst_valid", {63'd0, valid}, 64'd1);
    chk("pre_rst_pc", pc, 64'h800);
    chk("pre_rst_imem_adr", imem_adr, 64'h80C);
    ready = 1'b1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("async_rst_valid", {63'd0, valid}, 64'd0);
    chk("async_rst_pc", pc, 64'd0);
    chk("async_rst_pc_plus4", pc_plus4, 64'd0);
    chk("async_rst_instr", {32'd0, instr}, 64'd0);
    chk("async_rst_excp", {63'd0, excp}, 64'd0);
    chk("async_rst_imem_adr", imem_adr, 64'd0);
    repeat (2) tick();
    push_stream(64'h0, 64);
    rst_n = 1'b1;
    tick();
    chk("refetch_valid", {63'd0, valid}, 64'd1);
    chk("refetch_pc", pc, 64'h0);
    tick();
    chk("refetch_pc_next", pc, 64'h4);
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
